// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a one-entry instruction buffer.
//
// Keeps the next fetch address (pc_q), issues one instruction-memory
// request at a time and parks the returned word in a one-entry buffer that
// the IF/ID register samples. Branch redirects (Flush_i) discard the buffer
// and any in-flight response; stalls hold the buffer and the fetch address.
//
// Memory handshake: imem_req_o is the valid, imem_ack_i is the ready/response.
// A request is held with a stable imem_addr_o until imem_ack_i is seen in the
// same cycle as imem_req_o=1; that cycle completes the transfer and
// imem_data_i is sampled then. Only one request is ever outstanding.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   Flush_i, branchTarget_i redirect: drop buffer, fetch from branchTarget_i
//   Stall_i, memStall_i     hold the buffer (IF/ID does not advance)
//   imem_req_o/addr_o       request to instruction memory
//   imem_ack_i/data_i       response from instruction memory
//   instr_o/nowPC_o/valid_o buffered instruction, its PC, buffer-full flag
//   bubble_cnt_o            only with FETCH_BUBBLE_CNT_EN defined: cycles in
//                           which IF/ID advanced while the buffer was empty
//   o_dbg_state             controller state: 0=FETCH, 1=WAIT, 2=DRAIN
//
// Optional feature macro: FETCH_BUBBLE_CNT_EN (bubble counter + port).
module fetch_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        Flush_i,
  input  logic        Stall_i,
  input  logic        memStall_i,
  input  logic [31:0] branchTarget_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] nowPC_o,
  output logic        valid_o,
`ifdef FETCH_BUBBLE_CNT_EN
  output logic [31:0] bubble_cnt_o,
`endif
  output logic [1:0]  o_dbg_state
);

  localparam logic [31:0] NOP = 32'h00001033;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc;
  logic        r_buf_valid;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_addr_nxt;
  logic [31:0] w_buf_instr_nxt;
  logic [31:0] w_buf_pc_nxt;
  logic        w_buf_valid_nxt;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_load;
  logic        w_adv;
  logic        w_consume;

  assign w_adv     = ~Stall_i & ~memStall_i;
  assign w_consume = w_adv & r_buf_valid & ~Flush_i;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_addr_nxt      = r_addr;
    w_buf_instr_nxt = r_buf_instr;
    w_buf_pc_nxt    = r_buf_pc;
    w_buf_valid_nxt = r_buf_valid;
    w_req           = 1'b0;
    w_addr          = r_addr;
    w_load          = 1'b0;

    case (r_state)
      FETCH: begin
        w_addr = r_pc;
        // Issue only when the buffer will have room at this edge.
        if (!Flush_i && (!r_buf_valid || w_consume)) begin
          w_req      = 1'b1;
          w_addr_nxt = r_pc;
          w_pc_nxt   = r_pc + 32'd4;
          if (imem_ack_i) w_load = 1'b1;
          else            w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        w_req = 1'b1;
        if (imem_ack_i) begin
          w_load      = ~Flush_i;
          w_state_nxt = FETCH;
        end else if (Flush_i) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // The stale response still has to be collected; a flush here only
        // retargets pc_q. Once the ack arrives nothing else is pending.
        w_req = 1'b1;
        if (imem_ack_i) w_state_nxt = FETCH;
      end
      default: w_state_nxt = FETCH;
    endcase

    if (Flush_i) begin
      w_pc_nxt        = branchTarget_i;
      w_buf_valid_nxt = 1'b0;
      w_buf_instr_nxt = NOP;
    end else if (w_load) begin
      w_buf_instr_nxt = imem_data_i;
      w_buf_pc_nxt    = w_addr;
      w_buf_valid_nxt = 1'b1;
    end else if (w_consume) begin
      w_buf_valid_nxt = 1'b0;
      w_buf_instr_nxt = NOP;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= FETCH;
      r_pc        <= '0;
      r_addr      <= '0;
      r_buf_instr <= NOP;
      r_buf_pc    <= '0;
      r_buf_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_addr      <= w_addr_nxt;
      r_buf_instr <= w_buf_instr_nxt;
      r_buf_pc    <= w_buf_pc_nxt;
      r_buf_valid <= w_buf_valid_nxt;
    end
  end

  // Gated by reset so the request drops the instant reset is asserted.
  assign imem_req_o  = w_req & rst_i;
  assign imem_addr_o = w_addr;
  assign instr_o     = r_buf_instr;
  assign nowPC_o     = r_buf_pc;
  assign valid_o     = r_buf_valid;
  assign o_dbg_state = r_state;

`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_bubble_cnt <= '0;
    end else if (w_adv && !r_buf_valid && (r_bubble_cnt != 32'hFFFFFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a
// program-order reference model (expected PC stream, memory contents as a
// pure function of address) plus handshake and buffer rules.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00001033;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        rst_i;
  always #5 clk_i = ~clk_i;

  logic        Flush_i, Stall_i, memStall_i;
  logic [31:0] branchTarget_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] instr_o, nowPC_o;
  logic        valid_o;
  logic [1:0]  dbg_state;
`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_o;
`endif

  fetch_unit dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .Flush_i        (Flush_i),
    .Stall_i        (Stall_i),
    .memStall_i     (memStall_i),
    .branchTarget_i (branchTarget_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ack_i     (imem_ack_i),
    .imem_data_i    (imem_data_i),
    .instr_o        (instr_o),
    .nowPC_o        (nowPC_o),
    .valid_o        (valid_o),
`ifdef FETCH_BUBBLE_CNT_EN
    .bubble_cnt_o   (bubble_cnt_o),
`endif
    .o_dbg_state    (dbg_state)
  );

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  int   mem_lat;
  int   mem_cnt;
  logic stray_ack;

  assign imem_ack_i  = (imem_req_o && (mem_cnt >= mem_lat)) || stray_ack;
  assign imem_data_i = stray_ack ? 32'hDEADBEEF : mem_word(imem_addr_o);

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                          mem_cnt <= 0;
    else if (imem_req_o && !imem_ack_i) mem_cnt <= mem_cnt + 1;
    else                                 mem_cnt <= 0;
  end

  // ---------------- scoreboard / reference model ----------------
  int          checks = 0;
  int          errors = 0;
  int          consumed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] bub_model;
  logic        prev_flush, prev_hold, prev_pending;
  logic [31:0] prev_instr, prev_pc, prev_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic reset_model();
    exp_pc       = 32'd0;
    bub_model    = 32'd0;
    prev_flush   = 1'b0;
    prev_hold    = 1'b0;
    prev_pending = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  // Drive one cycle's inputs, then check the cycle against the model.
  task automatic drive(input logic fl, input logic st, input logic ms, input logic [31:0] tgt);
    logic adv;
    Flush_i = fl; Stall_i = st; memStall_i = ms; branchTarget_i = tgt;
    #1;
    adv = !st && !ms;
    if (rst_i) begin
      if (valid_o) chk("instr_matches_mem", instr_o, mem_word(nowPC_o));
      else         chk("nop_when_empty", instr_o, NOP);
      if (prev_flush) chk("empty_after_flush", valid_o, 1'b0);
      if (prev_hold) begin
        chk("stall_hold_valid", valid_o, 1'b1);
        chk("stall_hold_instr", instr_o, prev_instr);
        chk("stall_hold_pc", nowPC_o, prev_pc);
      end
      if (prev_pending) begin
        chk("req_held", imem_req_o, 1'b1);
        chk("addr_stable", imem_addr_o, prev_addr);
      end
      if (!fl && (!valid_o || adv)) chk("req_when_room", imem_req_o, 1'b1);
      if (!fl && !adv && valid_o)   chk("no_req_when_stalled", imem_req_o, 1'b0);
      if (!fl && adv && valid_o) begin
        chk("consume_pc", nowPC_o, exp_pc);
        chk("consume_instr", instr_o, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
`ifdef FETCH_BUBBLE_CNT_EN
      chk("bubble_cnt", bubble_cnt_o, bub_model);
      if (adv && !valid_o) bub_model = bub_model + 32'd1;
`endif
      if (fl) exp_pc = tgt;
      prev_flush   = fl;
      prev_hold    = !fl && !adv && valid_o;
      prev_instr   = instr_o;
      prev_pc      = nowPC_o;
      prev_pending = imem_req_o && !imem_ack_i;
      prev_addr    = imem_addr_o;
    end
  endtask

  task automatic hold_reset();
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_req", imem_req_o, 1'b0);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_instr", instr_o, NOP);
    chk("rst_nowpc", nowPC_o, 32'd0);
    chk("rst_state", dbg_state, 2'd0);
`ifdef FETCH_BUBBLE_CNT_EN
    chk("rst_bubble", bubble_cnt_o, 32'd0);
`endif
    rst_i = 1'b1;
    reset_model();
  endtask

  // ---------------- directed + random sequence ----------------
  logic [31:0] sv_instr, sv_pc, tgt;
  int          base_consumed;

  initial begin
    Flush_i = 0; Stall_i = 0; memStall_i = 0; branchTarget_i = 0;
    mem_lat = 0; stray_ack = 0;
    reset_model();
    @(negedge clk_i);
    hold_reset();

    // Zero-latency memory: one address per cycle, back-to-back buffer hits.
    exp_q.push_back(32'd0); exp_q.push_back(32'd4); exp_q.push_back(32'd8);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      chk("lat0_addr", imem_addr_o, exp_q.pop_front());
      if (i > 0) chk("lat0_nowpc", nowPC_o, 32'(4 * (i - 1)));
      tick();
    end

    // Latency 3: buffer empty for 3 cycles per instruction.
    mem_lat = 3;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0);
      chk("lat3_valid", valid_o, (i % 4 == 0));
      tick();
    end

    // Stall_i with full buffer for 4 cycles.
    chk("stall_entry_valid", valid_o, 1'b1);
    chk("stall_entry_pc", nowPC_o, 32'd16);
    sv_instr = instr_o; sv_pc = nowPC_o;
    mem_lat = 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0);
      chk("stall_req", imem_req_o, 1'b0);
      chk("stall_pc", nowPC_o, sv_pc);
      chk("stall_instr", instr_o, sv_instr);
      tick();
    end
    drive(0, 0, 0, 0);
    chk("after_stall_addr", imem_addr_o, sv_pc + 32'd4);
    tick();

    // Flush during WAIT at address 8 -> DRAIN, stale ack dropped, fetch 0x40.
    hold_reset();
    drive(0, 0, 0, 0); tick();
    drive(0, 0, 0, 0); tick();
    mem_lat = 5;
    drive(0, 0, 0, 0);
    chk("wait_addr", imem_addr_o, 32'd8);
    tick();
    chk("wait_state", dbg_state, 2'd1);
    drive(1, 0, 0, 32'h40);
    chk("flush_wait_req", imem_req_o, 1'b1);
    chk("flush_wait_addr", imem_addr_o, 32'd8);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("drain_state", dbg_state, 2'd2);
      drive(0, 0, 0, 0);
      chk("drain_req", imem_req_o, 1'b1);
      chk("drain_addr", imem_addr_o, 32'd8);
      chk("drain_valid", valid_o, 1'b0);
      tick();
    end
    mem_lat = 0;
    chk("post_drain_state", dbg_state, 2'd0);
    drive(0, 0, 0, 0);
    chk("target_req", imem_req_o, 1'b1);
    chk("target_addr", imem_addr_o, 32'h40);
    tick();
    mem_lat = 1;
    chk("target_valid", valid_o, 1'b1);
    chk("target_nowpc", nowPC_o, 32'h40);
    drive(0, 0, 0, 0); tick();

    // Flush coinciding with the ack: data dropped, next fetch is the target.
    drive(1, 0, 0, 32'h100);
    chk("flush_ack_setup", imem_ack_i, 1'b1);
    tick();
    drive(0, 0, 0, 0);
    chk("flush_ack_valid", valid_o, 1'b0);
    chk("flush_ack_addr", imem_addr_o, 32'h100);
    tick();
    drive(0, 0, 0, 0); tick();
    chk("flush_ack_nowpc", nowPC_o, 32'h100);

    // Wrap of the fetch address through 2^32.
    mem_lat = 0;
    drive(1, 0, 0, 32'hFFFFFFF8); tick();
    drive(0, 0, 0, 0); tick();
    drive(0, 0, 0, 0); tick();
    drive(0, 0, 0, 0);
    chk("wrap_addr", imem_addr_o, 32'd0);
    tick();
    chk("wrap_nowpc", nowPC_o, 32'd0);

    // Reset asserted while a request is outstanding; stray ack in reset.
    mem_lat = 10;
    drive(0, 0, 0, 0); tick();
    drive(0, 0, 0, 0);
    chk("pre_reset_req", imem_req_o, 1'b1);
    #1 rst_i = 1'b0;
    #1;
    chk("async_rst_req", imem_req_o, 1'b0);
    chk("async_rst_valid", valid_o, 1'b0);
    chk("async_rst_instr", instr_o, NOP);
`ifdef FETCH_BUBBLE_CNT_EN
    chk("async_rst_bubble", bubble_cnt_o, 32'd0);
`endif
    stray_ack = 1'b1;
    repeat (2) @(negedge clk_i);
    stray_ack = 1'b0;
    rst_i = 1'b1;
    reset_model();
    mem_lat = 2;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      if (i == 0) chk("restart_addr", imem_addr_o, 32'd0);
      chk("restart_empty", valid_o, 1'b0);
      tick();
    end
    chk("restart_valid", valid_o, 1'b1);
    chk("restart_nowpc", nowPC_o, 32'd0);
    chk("restart_instr", instr_o, mem_word(32'd0));

    // Randomized traffic against the program-order model.
    base_consumed = consumed;
    for (int i = 0; i < 600; i++) begin
      mem_lat = $urandom_range(0, 3);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF0 : ($urandom & 32'hFFFFFFFC);
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), tgt);
      tick();
    end
    chk("random_progress", (consumed - base_consumed > 100), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
